// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard / stall controller for the 5-stage core.
// Resolves load-use hazards, memory wait freezes, taken-branch flushes and
// multi-cycle MDU sequencing; keeps a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int MDU_LAT = 32,
   parameter int CNT_W   = 8,
   parameter int PERF_W  = 32
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic [4:0]        rs_addr_id,
   input  logic [4:0]        rt_addr_id,
   input  logic              rs_used_id,
   input  logic              rt_used_id,
   input  logic              mem_read_ex,
   input  logic [4:0]        rt_addr_ex,
   input  logic              mdu_start_id,
   input  logic              mem_busy,
   input  logic              branch_taken_id,
   input  logic              perf_clr,
   output logic              stall_pc,
   output logic              stall_if_id,
   output logic              bubble_id_ex,
   output logic              freeze_pipe,
   output logic              flush_if_id,
   output logic              mdu_busy,
   output logic [PERF_W-1:0] stall_cnt
);

   typedef enum logic [0:0] {RUN = 1'b0, MDU_WAIT = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    mdu_cnt_q, mdu_cnt_d;
   logic [PERF_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic                lu;

   // Load in EX feeding a source actually read in ID; r0 never hazards.
   assign lu = mem_read_ex && (rt_addr_ex != 5'd0) &&
               ((rs_used_id && (rs_addr_id == rt_addr_ex)) ||
                (rt_used_id && (rt_addr_id == rt_addr_ex)));

   // Priority decode: mem wait > MDU wait > load-use > normal run.
   always_comb begin
      state_d      = state_q;
      mdu_cnt_d    = mdu_cnt_q;
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      bubble_id_ex = 1'b0;
      freeze_pipe  = 1'b0;
      flush_if_id  = 1'b0;
      mdu_busy     = 1'b0;
      if (!reset_) begin
         mdu_busy = (state_q == MDU_WAIT);
         if (mem_busy) begin
            // Whole pipe freezes; the MDU count pauses rather than advancing.
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            freeze_pipe = 1'b1;
         end else if (state_q == MDU_WAIT) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            if (mdu_cnt_q == '0) state_d = RUN;
            else                 mdu_cnt_d = mdu_cnt_q - 1'b1;
         end else if (lu) begin
            // One bubble; MEM forwarding covers the consumer next cycle.
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
         end else begin
            flush_if_id = branch_taken_id;
            if (mdu_start_id) begin
               state_d   = MDU_WAIT;
               mdu_cnt_d = CNT_W'(MDU_LAT - 1);
            end
         end
      end
   end

   // Stall counter next value: clear wins, otherwise saturating increment.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (perf_clr)                              stall_cnt_d = '0;
      else if (stall_pc && (stall_cnt_q != '1))  stall_cnt_d = stall_cnt_q + 1'b1;
   end

   // State, MDU countdown and perf counter registers.
   always_ff @(posedge clk or posedge reset_) begin
      if (reset_) begin
         state_q     <= RUN;
         mdu_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mdu_cnt_q   <= mdu_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MDU_LAT = 4, PERF_W = 4).
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset_;
   logic [4:0] rs_addr_id, rt_addr_id, rt_addr_ex;
   logic       rs_used_id, rt_used_id, mem_read_ex, mdu_start_id;
   logic       mem_busy, branch_taken_id, perf_clr;
   logic       stall_pc, stall_if_id, bubble_id_ex, freeze_pipe, flush_if_id, mdu_busy;
   logic [3:0] stall_cnt;
   logic [5:0] outs;

   int n_chk = 0;
   int n_err = 0;

   hazard_ctrl #(.MDU_LAT(4), .CNT_W(8), .PERF_W(4)) dut (
      .clk(clk), .reset_(reset_),
      .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id),
      .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
      .mem_read_ex(mem_read_ex), .rt_addr_ex(rt_addr_ex),
      .mdu_start_id(mdu_start_id), .mem_busy(mem_busy),
      .branch_taken_id(branch_taken_id), .perf_clr(perf_clr),
      .stall_pc(stall_pc), .stall_if_id(stall_if_id),
      .bubble_id_ex(bubble_id_ex), .freeze_pipe(freeze_pipe),
      .flush_if_id(flush_if_id), .mdu_busy(mdu_busy),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // {stall_pc, stall_if_id, bubble, freeze, flush, mdu_busy}
   assign outs = {stall_pc, stall_if_id, bubble_id_ex, freeze_pipe, flush_if_id, mdu_busy};

   localparam logic [5:0] O_IDLE  = 6'b000000;
   localparam logic [5:0] O_LU    = 6'b111000;
   localparam logic [5:0] O_FLUSH = 6'b000010;
   localparam logic [5:0] O_MDU   = 6'b111001;
   localparam logic [5:0] O_MEMW  = 6'b110100;
   localparam logic [5:0] O_MEMMD = 6'b110101;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to the next cycle; inputs change at the falling edge.
   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic clr_in();
      rs_addr_id = 0; rt_addr_id = 0; rt_addr_ex = 0;
      rs_used_id = 0; rt_used_id = 0; mem_read_ex = 0; mdu_start_id = 0;
      mem_busy = 0; branch_taken_id = 0; perf_clr = 0;
   endtask

   task automatic set_lu(input logic [4:0] ra);
      mem_read_ex = 1; rt_addr_ex = ra; rs_used_id = 1; rs_addr_id = ra;
   endtask

   initial begin
      clr_in();
      reset_ = 1;
      // Reset: outputs forced low even with a hazard present.
      nxt(); set_lu(5'd5); mem_busy = 1; #1;
      chk("rst_outs", outs, O_IDLE);
      chk("rst_cnt", stall_cnt, 0);
      nxt(); clr_in(); reset_ = 0; #1;
      chk("run_idle", outs, O_IDLE);

      // Load-use on rs: one stall cycle.
      nxt(); set_lu(5'd5); #1;
      chk("lu_rs", outs, O_LU);
      nxt(); clr_in(); #1;
      chk("lu_gone", outs, O_IDLE);
      chk("lu_cnt", stall_cnt, 1);
      // r0 destination never hazards.
      set_lu(5'd0); #1;
      chk("lu_r0", outs, O_IDLE);
      // rt path match; rs match but unused.
      nxt(); clr_in(); mem_read_ex = 1; rt_addr_ex = 7; rt_used_id = 1; rt_addr_id = 7; #1;
      chk("lu_rt", outs, O_LU);
      nxt(); clr_in(); mem_read_ex = 1; rt_addr_ex = 7; rs_addr_id = 7; #1;
      chk("lu_unused", outs, O_IDLE);
      // Branch flush, and suppressed by load-use.
      nxt(); clr_in(); branch_taken_id = 1; #1;
      chk("br_flush", outs, O_FLUSH);
      set_lu(5'd9); #1;
      chk("br_lu", outs, O_LU);
      // mem_busy with load-use: freeze only, then hazard re-evaluated.
      nxt(); clr_in(); set_lu(5'd3); mem_busy = 1; #1;
      chk("mem_lu", outs, O_MEMW);
      nxt(); mem_busy = 0; #1;
      chk("mem_lu_drop", outs, O_LU);

      // MDU op, 4 stall cycles; branch ignored while waiting.
      nxt(); clr_in(); perf_clr = 1;
      nxt(); perf_clr = 0; mdu_start_id = 1; #1;
      chk("mdu_T", outs, O_IDLE);
      for (int i = 1; i <= 4; i++) begin
         nxt(); clr_in(); if (i == 2) branch_taken_id = 1; #1;
         chk($sformatf("mdu_T%0d", i), outs, O_MDU);
      end
      nxt(); #1;
      chk("mdu_done", outs, O_IDLE);
      chk("mdu_cnt", stall_cnt, 4);

      // MDU op with mem wait at T+2, T+3: stall extends to T+6.
      nxt(); clr_in(); perf_clr = 1;
      nxt(); perf_clr = 0; mdu_start_id = 1; #1;
      chk("mdm_T", outs, O_IDLE);
      for (int i = 1; i <= 6; i++) begin
         nxt(); clr_in(); mem_busy = (i == 2 || i == 3); #1;
         chk($sformatf("mdm_T%0d", i), outs, (i == 2 || i == 3) ? O_MEMMD : O_MDU);
      end
      nxt(); clr_in(); #1;
      chk("mdm_done", outs, O_IDLE);
      chk("mdm_cnt", stall_cnt, 6);

      // Reset during MDU wait aborts to RUN.
      nxt(); mdu_start_id = 1;
      nxt(); clr_in(); #1;
      chk("rmid_T1", outs, O_MDU);
      nxt(); reset_ = 1; #1;
      chk("rmid_outs", outs, O_IDLE);
      chk("rmid_cnt", stall_cnt, 0);
      nxt(); reset_ = 0; #1;
      chk("rmid_rel", outs, O_IDLE);
      nxt(); #1;
      chk("rmid_run", outs, O_IDLE);
      chk("rmid_cnt2", stall_cnt, 0);

      // Saturation at 15 after 20 mem_busy cycles; clear beats increment.
      nxt(); mem_busy = 1;
      for (int i = 0; i < 20; i++) nxt();
      #1;
      chk("sat_15", stall_cnt, 15);
      nxt(); #1;
      chk("sat_hold", stall_cnt, 15);
      perf_clr = 1;
      nxt(); #1;
      chk("sat_clr", stall_cnt, 0);
      clr_in();
      nxt(); #1;
      chk("sat_idle", stall_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
